// File: rtl/arbitro_ponderado.sv
// arbitro_ponderado: weighted round-robin arbiter that moves words from four
// source FIFOs to four destination FIFOs. It pops the granted source and pushes
// the word to its destination one cycle later. Destination almost-full flags
// block pops.
module arbitro_ponderado #(
   parameter logic [2:0] W0 = 3'd4,
   parameter logic [2:0] W1 = 3'd3,
   parameter logic [2:0] W2 = 3'd2,
   parameter logic [2:0] W3 = 3'd1
) (
   input  logic       clk,
   input  logic       reset_L,
   input  logic [3:0] FIFO_empty,
   input  logic [3:0] Almost_full,
   input  logic [7:0] dest,
   output logic [3:0] Pops,
   output logic [3:0] Push,
   output logic [1:0] grant,
   output logic       idle
);

   typedef enum logic {IDLE, SERVE} state_t;

   state_t     state_q, state_d;
   logic [1:0] grant_q, grant_d;
   logic [2:0] credit_q, credit_d;
   logic [3:0] push_q, push_d;

   logic [1:0] head_dest;
   logic [1:0] next_grant;
   logic       eligible;
   logic       pop_en;

   // A weight of zero still grants one pop per round.
   function automatic logic [2:0] weight_of(input logic [1:0] idx);
      logic [2:0] w;
      case (idx)
         2'd0: w = W0;
         2'd1: w = W1;
         2'd2: w = W2;
         2'd3: w = W3;
      endcase
      return (w == 3'd0) ? 3'd1 : w;
   endfunction

   assign next_grant = grant_q + 2'd1;

   // Select the head-word destination of the granted source and decide whether it may pop.
   always_comb begin
      case (grant_q)
         2'd0: head_dest = dest[1:0];
         2'd1: head_dest = dest[3:2];
         2'd2: head_dest = dest[5:4];
         2'd3: head_dest = dest[7:6];
      endcase
      eligible = !FIFO_empty[grant_q] && !Almost_full[head_dest];
      pop_en   = reset_L && (state_q == SERVE) && eligible;
   end

   // State, grant, credit and push registers with synchronous active-low reset.
   always_ff @(posedge clk) begin
      if (!reset_L) begin
         state_q  <= IDLE;
         grant_q  <= '0;
         credit_q <= weight_of(2'd0);
         push_q   <= '0;
      end else begin
         state_q  <= state_d;
         grant_q  <= grant_d;
         credit_q <= credit_d;
         push_q   <= push_d;
      end
   end

   // Next state: IDLE/SERVE transitions, credit consumption and grant rotation.
   always_comb begin
      state_d  = state_q;
      grant_d  = grant_q;
      credit_d = credit_q;
      push_d   = pop_en ? (4'b0001 << head_dest) : '0;
      case (state_q)
         IDLE: begin
            if (FIFO_empty != 4'b1111) state_d = SERVE;
         end
         SERVE: begin
            if (FIFO_empty == 4'b1111) begin
               state_d = IDLE;
            end else if (pop_en && (credit_q > 3'd1)) begin
               credit_d = credit_q - 3'd1;
            end else begin
               // Last credit used, or a bubble: move on and drop any leftover credit.
               grant_d  = next_grant;
               credit_d = weight_of(next_grant);
            end
         end
      endcase
   end

   // Outputs: combinational pop from current state, registered push.
   always_comb begin
      Pops  = pop_en ? (4'b0001 << grant_q) : '0;
      Push  = push_q;
      grant = grant_q;
      idle  = (state_q == IDLE);
   end

endmodule

// File: tb/tb_arbitro_ponderado.sv
// Self-checking bench for arbitro_ponderado. Expected pushes are queued when
// the corresponding pop cycle is driven and compared one cycle later.
module tb_arbitro_ponderado;

   logic       clk = 1'b0;
   logic       reset_L;
   logic [3:0] FIFO_empty;
   logic [3:0] Almost_full;
   logic [7:0] dest;
   logic [3:0] Pops, Push, Pops6, Push6;
   logic [1:0] grant, grant6;
   logic       idle, idle6;

   int total = 0;
   int bad   = 0;

   logic [3:0] sb[$];
   logic [3:0] sb6[$];

   always #5 clk = ~clk;

   arbitro_ponderado dut (
      .clk(clk), .reset_L(reset_L), .FIFO_empty(FIFO_empty), .Almost_full(Almost_full),
      .dest(dest), .Pops(Pops), .Push(Push), .grant(grant), .idle(idle)
   );

   arbitro_ponderado #(.W0(3'd0)) u6 (
      .clk(clk), .reset_L(reset_L), .FIFO_empty(FIFO_empty), .Almost_full(Almost_full),
      .dest(dest), .Pops(Pops6), .Push(Push6), .grant(grant6), .idle(idle6)
   );

   function automatic logic [3:0] onehot(input logic [1:0] i);
      return 4'b0001 << i;
   endfunction

   // Drive one cycle of inputs just after the falling edge, then settle.
   task automatic step(input logic rst, input logic [3:0] fe, input logic [3:0] af,
                       input logic [7:0] d);
      @(negedge clk);
      reset_L     = rst;
      FIFO_empty  = fe;
      Almost_full = af;
      dest        = d;
      #1;
   endtask

   task automatic test_reset();
      step(1'b0, 4'b1111, 4'b0000, 8'h00);
      step(1'b0, 4'b1111, 4'b0000, 8'h00);
      total++; if (Pops !== 4'b0000) begin bad++; $display("FAIL reset_pops got=%b want=0000", Pops); end
      total++; if (Push !== 4'b0000) begin bad++; $display("FAIL reset_push got=%b want=0000", Push); end
      total++; if (grant !== 2'd0) begin bad++; $display("FAIL reset_grant got=%0d want=0", grant); end
      total++; if (idle !== 1'b1) begin bad++; $display("FAIL reset_idle got=%b want=1", idle); end
      total++; if (Push6 !== 4'b0000) begin bad++; $display("FAIL reset_push6 got=%b want=0000", Push6); end
      sb.delete();  sb.push_back(4'b0000);
      sb6.delete(); sb6.push_back(4'b0000);
   endtask

   task automatic test_weights();
      int unsigned wt[4] = '{4, 3, 2, 1};
      logic [3:0] ph;
      test_reset();
      step(1'b1, 4'b0000, 4'b0000, 8'h00);
      total++; if (Pops !== 4'b0000) begin bad++; $display("FAIL w_idle_pops got=%b want=0000", Pops); end
      ph = sb.pop_front();
      total++; if (Push !== ph) begin bad++; $display("FAIL w_idle_push got=%b want=%b", Push, ph); end
      sb.push_back(4'b0000);
      for (int r = 0; r < 2; r++)
         for (int s = 0; s < 4; s++)
            for (int unsigned k = 0; k < wt[s]; k++) begin
               step(1'b1, 4'b0000, 4'b0000, 8'h00);
               total++; if (Pops !== onehot(2'(s))) begin bad++; $display("FAIL w_pops r=%0d s=%0d k=%0d got=%b want=%b", r, s, k, Pops, onehot(2'(s))); end
               total++; if (grant !== 2'(s)) begin bad++; $display("FAIL w_grant got=%0d want=%0d", grant, s); end
               ph = sb.pop_front();
               total++; if (Push !== ph) begin bad++; $display("FAIL w_push got=%b want=%b", Push, ph); end
               sb.push_back(4'b0001);
            end
   endtask

   task automatic test_single_source();
      logic [3:0] ph, ep;
      test_reset();
      step(1'b1, 4'b1011, 4'b0000, 8'h30);
      ph = sb.pop_front();
      total++; if (Push !== ph) begin bad++; $display("FAIL ss_idle_push got=%b want=%b", Push, ph); end
      sb.push_back(4'b0000);
      for (int r = 0; r < 2; r++)
         for (int g = 0; g < 4; g++)
            for (int k = 0; k < ((g == 2) ? 2 : 1); k++) begin
               step(1'b1, 4'b1011, 4'b0000, 8'h30);
               ep = (g == 2) ? 4'b0100 : 4'b0000;
               total++; if (Pops !== ep) begin bad++; $display("FAIL ss_pops g=%0d got=%b want=%b", g, Pops, ep); end
               total++; if (grant !== 2'(g)) begin bad++; $display("FAIL ss_grant got=%0d want=%0d", grant, g); end
               ph = sb.pop_front();
               total++; if (Push !== ph) begin bad++; $display("FAIL ss_push got=%b want=%b", Push, ph); end
               sb.push_back((g == 2) ? 4'b1000 : 4'b0000);
            end
   endtask

   task automatic test_almost_full();
      logic [3:0] ph, ep;
      test_reset();
      step(1'b1, 4'b0000, 4'b0010, 8'h01);
      ph = sb.pop_front();
      total++; if (Push !== ph) begin bad++; $display("FAIL af_idle_push got=%b want=%b", Push, ph); end
      sb.push_back(4'b0000);
      // grant 0 bubble, then P1 x3, P2 x2, P3 x1
      for (int c = 0; c < 7; c++) begin
         step(1'b1, 4'b0000, 4'b0010, 8'h01);
         ep = (c == 0) ? 4'b0000 : (c < 4) ? 4'b0010 : (c < 6) ? 4'b0100 : 4'b1000;
         total++; if (Pops !== ep) begin bad++; $display("FAIL af_pops c=%0d got=%b want=%b", c, Pops, ep); end
         ph = sb.pop_front();
         total++; if (Push !== ph) begin bad++; $display("FAIL af_push c=%0d got=%b want=%b", c, Push, ph); end
         sb.push_back((c == 0) ? 4'b0000 : 4'b0001);
      end
      for (int c = 0; c < 4; c++) begin
         step(1'b1, 4'b0000, 4'b0000, 8'h01);
         total++; if (Pops !== 4'b0001) begin bad++; $display("FAIL af_clear_pops c=%0d got=%b want=0001", c, Pops); end
         ph = sb.pop_front();
         total++; if (Push !== ph) begin bad++; $display("FAIL af_clear_push c=%0d got=%b want=%b", c, Push, ph); end
         sb.push_back(4'b0010);
      end
      step(1'b1, 4'b0000, 4'b0000, 8'h01);
      ph = sb.pop_front();
      total++; if (Push !== ph) begin bad++; $display("FAIL af_last_push got=%b want=%b", Push, ph); end
      sb.push_back(4'b0000);
   endtask

   task automatic test_idle();
      logic [3:0] fe_t[8] = '{4'b0000, 4'b0000, 4'b0000, 4'b1111, 4'b1111, 4'b1110, 4'b1110, 4'b1110};
      logic [3:0] ep_t[8] = '{4'b0000, 4'b0001, 4'b0001, 4'b0000, 4'b0000, 4'b0000, 4'b0001, 4'b0001};
      logic       id_t[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0};
      logic [3:0] ph;
      test_reset();
      for (int c = 0; c < 8; c++) begin
         step(1'b1, fe_t[c], 4'b0000, 8'h00);
         total++; if (Pops !== ep_t[c]) begin bad++; $display("FAIL id_pops c=%0d got=%b want=%b", c, Pops, ep_t[c]); end
         total++; if (idle !== id_t[c]) begin bad++; $display("FAIL id_idle c=%0d got=%b want=%b", c, idle, id_t[c]); end
         ph = sb.pop_front();
         total++; if (Push !== ph) begin bad++; $display("FAIL id_push c=%0d got=%b want=%b", c, Push, ph); end
         sb.push_back(ep_t[c]);
      end
      total++; if (grant !== 2'd0) begin bad++; $display("FAIL id_grant got=%0d want=0", grant); end
   endtask

   task automatic test_reset_mid();
      logic       rs_t[14] = '{1, 1, 1, 1, 1, 1, 0, 0, 1, 1, 1, 1, 1, 1};
      logic [3:0] ep_t[14] = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010, 4'b0000,
                               4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0010};
      logic [3:0] np_t[14] = '{4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0100, 4'b0000,
                               4'b0000, 4'b0000, 4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0100};
      logic [3:0] ph;
      test_reset();
      for (int c = 0; c < 14; c++) begin
         step(rs_t[c], 4'b0000, 4'b0000, 8'h08);
         total++; if (Pops !== ep_t[c]) begin bad++; $display("FAIL rm_pops c=%0d got=%b want=%b", c, Pops, ep_t[c]); end
         ph = sb.pop_front();
         total++; if (Push !== ph) begin bad++; $display("FAIL rm_push c=%0d got=%b want=%b", c, Push, ph); end
         sb.push_back(np_t[c]);
         if (c == 7) begin
            total++; if (grant !== 2'd0) begin bad++; $display("FAIL rm_grant got=%0d want=0", grant); end
            total++; if (idle !== 1'b1) begin bad++; $display("FAIL rm_idle got=%b want=1", idle); end
         end
      end
   endtask

   task automatic test_zero_weight();
      logic [3:0] ph, ep;
      test_reset();
      step(1'b1, 4'b1110, 4'b0000, 8'h00);
      total++; if (idle6 !== 1'b1) begin bad++; $display("FAIL zw_idle got=%b want=1", idle6); end
      ph = sb6.pop_front();
      total++; if (Push6 !== ph) begin bad++; $display("FAIL zw_idle_push got=%b want=%b", Push6, ph); end
      sb6.push_back(4'b0000);
      for (int r = 0; r < 3; r++)
         for (int g = 0; g < 4; g++) begin
            step(1'b1, 4'b1110, 4'b0000, 8'h00);
            ep = (g == 0) ? 4'b0001 : 4'b0000;
            total++; if (Pops6 !== ep) begin bad++; $display("FAIL zw_pops r=%0d g=%0d got=%b want=%b", r, g, Pops6, ep); end
            total++; if (grant6 !== 2'(g)) begin bad++; $display("FAIL zw_grant got=%0d want=%0d", grant6, g); end
            ph = sb6.pop_front();
            total++; if (Push6 !== ph) begin bad++; $display("FAIL zw_push got=%b want=%b", Push6, ph); end
            sb6.push_back(ep);
         end
   endtask

   initial begin
      reset_L     = 1'b0;
      FIFO_empty  = 4'b1111;
      Almost_full = 4'b0000;
      dest        = 8'h00;
      test_reset();
      test_weights();
      test_single_source();
      test_almost_full();
      test_idle();
      test_reset_mid();
      test_zero_weight();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
